// File: rtl/selector8.sv
// selector8 -- 8-bit two-way plumbing mux.
//   sel : 0 selects d0, 1 selects d1
//   d0  : first 8-bit input
//   d1  : second 8-bit input
//   y   : selected 8-bit output
module selector8 (
    input  logic       sel,
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    output logic [7:0] y
);

    always_comb begin
        y = sel ? d1 : d0;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- round-robin merge of two 8-bit valid/ready streams (A, B)
// into a single registered output stage, at most one beat per cycle.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_a_data/valid, o_a_ready : source A stream
//   i_b_data/valid, o_b_ready : source B stream
//   o_c_data/valid, i_c_ready : registered output stream
//   o_s                   : source of the beat in o_c_data (0 = A, 1 = B)
module rr_arbiter8 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_a_data,
    input  logic       i_a_valid,
    output logic       o_a_ready,
    input  logic [7:0] i_b_data,
    input  logic       i_b_valid,
    output logic       o_b_ready,
    output logic [7:0] o_c_data,
    output logic       o_c_valid,
    input  logic       i_c_ready,
    output logic       o_s
);

    // Which source wins a tie on the next contested cycle.
    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t      prio;
    logic       load;
    logic       grant_a;
    logic       grant_b;
    logic [7:0] sel_data;

    // The output register can take a new beat when it is empty or being drained.
    always_comb begin
        load    = ~o_c_valid | i_c_ready;
        grant_a = 1'b0;
        grant_b = 1'b0;
        unique case ({i_a_valid, i_b_valid})
            2'b10:   grant_a = 1'b1;
            2'b01:   grant_b = 1'b1;
            2'b11: begin
                if (prio == PRIO_A) grant_a = 1'b1;
                else                grant_b = 1'b1;
            end
            default: ;
        endcase
    end

    // Readies depend only on control signals; reset suppresses any accept.
    always_comb begin
        o_a_ready = ~i_rst & load & grant_a;
        o_b_ready = ~i_rst & load & grant_b;
    end

    selector8 u_selector8 (
        .sel (grant_b),
        .d0  (i_a_data),
        .d1  (i_b_data),
        .y   (sel_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_c_valid <= 1'b0;
            o_c_data  <= '0;
            o_s       <= 1'b0;
            prio      <= PRIO_A;
        end else if (load) begin
            if (grant_a || grant_b) begin
                o_c_data  <= sel_data;
                o_s       <= grant_b;
                o_c_valid <= 1'b1;
                // The source just served loses the next tie.
                prio      <= grant_b ? PRIO_A : PRIO_B;
            end else begin
                o_c_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 8 bits.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_a_data  input  8  source A payload.
REQ-005 i_a_valid  input  1  source A offers i_a_data this cycle.
REQ-006 o_a_ready  output  1  source A beat accepted this cycle when high with i_a_valid.
REQ-007 i_b_data  input  8  source B payload.
REQ-008 i_b_valid  input  1  source B offers i_b_data this cycle.
REQ-009 o_b_ready  output  1  source B beat accepted this cycle when high with i_b_valid.
REQ-010 o_c_data  output  8  registered selected payload.
REQ-011 o_c_valid  output  1  o_c_data holds an unconsumed beat.
REQ-012 i_c_ready  input  1  downstream consumes o_c_data this cycle when high with o_c_valid.
REQ-013 o_s  output  1  source of the beat in o_c_data (0 = A, 1 = B).

Function
REQ-014 Block SHALL arbitrate two valid/ready streams into one registered output stage, one beat per cycle maximum.
REQ-015 Internal load enable SHALL be load = ~o_c_valid | i_c_ready.
REQ-016 Grant SHALL be: only A valid -> A; only B valid -> B; both valid -> A if prio=0, else B; neither valid -> none.
REQ-017 o_a_ready SHALL equal load & grant==A; o_b_ready SHALL equal load & grant==B; never both high.
REQ-018 Ready outputs SHALL be combinational from load, i_a_valid, i_b_valid and prio only; no path from data inputs.
REQ-019 On accept of A: o_c_data<=i_a_data, o_s<=0, o_c_valid<=1, prio<=1 next cycle.
REQ-020 On accept of B: o_c_data<=i_b_data, o_s<=1, o_c_valid<=1, prio<=0 next cycle.
REQ-021 load=1 with no grant: o_c_valid<=0; o_c_data, o_s and prio SHALL hold.
REQ-022 load=0 (o_c_valid=1, i_c_ready=0): o_c_data, o_s, o_c_valid, prio SHALL hold; both readies low.
REQ-023 Latency input-accept to o_c_valid SHALL be exactly 1 cycle; simultaneous consume and accept SHALL sustain 1 beat/cycle with no bubble.
REQ-024 With both sources continuously valid and i_c_ready=1, grants SHALL strictly alternate A,B,A,B.
REQ-025 A single continuously valid source SHALL receive every grant (no idle slots forced by prio).
REQ-026 Output payload selection SHALL be performed by one selector8 instance with select = grant==B.

Reset
REQ-027 While i_rst=1 at a clock edge: o_c_valid<=0, o_c_data<=8'h00, o_s<=0, prio<=0.
REQ-028 While i_rst=1, o_a_ready and o_b_ready SHALL be 0; no beat is accepted.
REQ-029 Reset asserted mid-transfer SHALL discard any held output beat; first post-reset tie SHALL go to A.

Structure
REQ-030 No shared package; no typedefs or constants exported; prio encoding is local.
REQ-031 One sub-module: selector8 (existing plumbing mux) for the data path; prio register, output register and grant logic SHALL be in rr_arbiter8.
REQ-032 Implementation SHALL be synthesizable, lint-clean, no latches, no combinational loops through ready/valid.

Verification
REQ-033 Reset then A valid 8'h11, B idle, i_c_ready=1 -> o_a_ready=1 cycle 0; cycle 1 o_c_valid=1, o_c_data=8'h11, o_s=0.
REQ-034 Both valid continuously (A=8'hA0.., B=8'hB0..), i_c_ready=1 -> output sequence A0,B0,A1,B1 on consecutive cycles, o_s 0,1,0,1.
REQ-035 Output full with 8'h55, i_c_ready=0 for 3 cycles, A and B valid -> o_c_data stays 8'h55, both readies 0; on i_c_ready=1 next grant follows prio.
REQ-036 Only B valid for 4 cycles with i_c_ready=1 -> 4 B beats back-to-back, o_a_ready=0 throughout.
REQ-037 i_rst=1 while o_c_valid=1 holding 8'h77 -> next cycle o_c_valid=0, o_c_data=8'h00; first tie afterwards grants A.
REQ-038 Random valid/ready stimulus 10k cycles -> scoreboard: no loss, no duplication, per-source order preserved, never both readies high.
